hwag_period_capture_n: RTL and testbench

//  Measures tooth periods between successive VR edge strobes (edge0/edge1 from hwag_vr_capture) as

---
 rtl/hwag_period_capture_n_if.sv | 24 ++
 rtl/hwag_period_capture_n.sv | 85 ++++++++
 tb/tb_hwag_period_capture_n.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/hwag_period_capture_n_if.sv
// Tooth-period capture bus: edge strobe and clock enable in, period history and status out.
// master drives ena/edge_in and reads results; slave is the capture block.
interface hwag_period_capture_n_if #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 3
);
    logic                     ena;
    logic                     edge_in;
    logic [DEPTH*WIDTH-1:0]   q;
    logic [DEPTH-1:0]         valid;
    logic                     cap;
    logic                     gap;
    logic                     stall;

    modport master (
        output ena, edge_in,
        input  q, valid, cap, gap, stall
    );

    modport slave (
        input  ena, edge_in,
        output q, valid, cap, gap, stall
    );
endinterface

// File: rtl/hwag_period_capture_n.sv
// Measures VR tooth periods in enabled clock cycles, keeps a DEPTH-deep history.
// Ports: clk, rst (sync active-high), bus (slave): ena, edge_in -> q, valid, cap, gap, stall.
module hwag_period_capture_n #(
    parameter int WIDTH   = 24,
    parameter int DEPTH   = 3,
    parameter int GAP_SHL = 1
) (
    input  logic clk,
    input  logic rst,
    hwag_period_capture_n_if.slave bus
);
    localparam int GW = WIDTH + GAP_SHL;
    localparam logic [WIDTH-1:0] MAX   = '1;
    localparam logic [WIDTH-1:0] MAXM1 = MAX - WIDTH'(1);

    logic [WIDTH-1:0]       cnt;
    logic                   started;
    logic [DEPTH*WIDTH-1:0] hist;
    logic [DEPTH-1:0]       valid_r;
    logic                   cap_r;
    logic                   gap_r;
    logic                   stall_r;

    logic [DEPTH*WIDTH-1:0] hist_sh;
    logic [DEPTH-1:0]       valid_sh;
    logic [GW-1:0]          cnt_x;
    logic [GW-1:0]          thr;
    logic                   longer;

    // Shifted history; with a single stage the shift degenerates to a load.
    if (DEPTH == 1) begin : g_one
        assign hist_sh  = cnt;
        assign valid_sh = 1'b1;
    end else begin : g_many
        assign hist_sh  = {hist[(DEPTH-1)*WIDTH-1:0], cnt};
        assign valid_sh = {valid_r[DEPTH-2:0], 1'b1};
    end

    // Threshold widened so the shift never drops high bits.
    assign cnt_x  = GW'(cnt);
    assign thr    = GW'(hist[WIDTH-1:0]) << GAP_SHL;
    assign longer = cnt_x > thr;

    always_ff @(posedge clk) begin
        cap_r <= 1'b0;
        gap_r <= 1'b0;
        if (rst) begin
            cnt     <= '0;
            started <= 1'b0;
            hist    <= '0;
            valid_r <= '0;
            stall_r <= 1'b0;
        end else if (bus.ena) begin
            if (bus.edge_in) begin
                cnt <= WIDTH'(1);
                if (started && cnt != MAX) begin
                    hist    <= hist_sh;
                    valid_r <= valid_sh;
                    cap_r   <= 1'b1;
                    gap_r   <= valid_r[0] & longer;
                end else begin
                    // Reference edge: restarts measurement only.
                    started <= 1'b1;
                    stall_r <= 1'b0;
                end
            end else if (cnt < MAXM1) begin
                cnt <= cnt + WIDTH'(1);
            end else if (cnt == MAXM1) begin
                cnt <= MAX;
                // Wheel stopped: history kept but marked stale.
                if (started) begin
                    stall_r <= 1'b1;
                    valid_r <= '0;
                    started <= 1'b0;
                end
            end
        end
    end

    assign bus.q     = hist;
    assign bus.valid = valid_r;
    assign bus.cap   = cap_r;
    assign bus.gap   = gap_r;
    assign bus.stall = stall_r;
endmodule

// File: tb/tb_hwag_period_capture_n.sv
// Directed bench for hwag_period_capture_n, plus a model-checked DEPTH=5 instance.
// Instances: u0 (W=8,D=3,G=1), u1 (W=8,D=5,G=2).
module tb_hwag_period_capture_n;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    hwag_period_capture_n_if #(.WIDTH(8), .DEPTH(3)) b0 ();
    hwag_period_capture_n_if #(.WIDTH(8), .DEPTH(5)) b1 ();

    hwag_period_capture_n #(.WIDTH(8), .DEPTH(3), .GAP_SHL(1)) u0 (
        .clk (clk),
        .rst (rst),
        .bus (b0.slave)
    );

    hwag_period_capture_n #(.WIDTH(8), .DEPTH(5), .GAP_SHL(2)) u1 (
        .clk (clk),
        .rst (rst),
        .bus (b1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input logic e, input logic en);
        b0.edge_in = e;
        b0.ena     = en;
        @(posedge clk);
        #1;
        b0.edge_in = 1'b0;
    endtask

    // Edge arrives n enabled cycles after the previous one.
    task automatic edge_after(input int n);
        repeat (n - 1) tick(1'b0, 1'b1);
        tick(1'b1, 1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1'b0, 1'b1);
        rst = 1'b0;
    endtask

    // Reference model for u1
    int         m_cnt;
    int         m_q[5];
    logic [4:0] m_valid;
    bit         m_started;
    bit         m_cap;
    bit         m_gap;

    task automatic m_step(input logic r, input logic e, input logic en);
        logic [39:0] eq;
        m_cap = 0;
        m_gap = 0;
        if (r) begin
            m_cnt = 0; m_started = 0; m_valid = '0;
            foreach (m_q[i]) m_q[i] = 0;
        end else if (en) begin
            if (e) begin
                if (m_started && m_cnt < 255) begin
                    m_gap = m_valid[0] && (m_cnt > m_q[0] * 4);
                    for (int i = 4; i > 0; i--) m_q[i] = m_q[i-1];
                    m_q[0]  = m_cnt;
                    m_valid = {m_valid[3:0], 1'b1};
                    m_cap   = 1;
                end else begin
                    m_started = 1;
                end
                m_cnt = 1;
            end else if (m_cnt < 254) begin
                m_cnt++;
            end else if (m_cnt == 254) begin
                m_cnt = 255;
                if (m_started) begin
                    m_valid = '0;
                    m_started = 0;
                end
            end
        end
        rst = r;
        b1.edge_in = e;
        b1.ena     = en;
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) eq[i*8 +: 8] = m_q[i][7:0];
        chk("m_q", b1.q, eq);
        chk("m_valid", b1.valid, m_valid);
        chk("m_cap", b1.cap, m_cap);
        chk("m_gap", b1.gap, m_gap);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b0;
        b0.ena = 1'b0; b0.edge_in = 1'b0;
        b1.ena = 1'b0; b1.edge_in = 1'b0;

        // 1: regular teeth
        do_reset();
        chk("rst_q", b0.q, 0);
        chk("rst_valid", b0.valid, 0);
        chk("rst_cap", b0.cap, 0);
        chk("rst_gap", b0.gap, 0);
        chk("rst_stall", b0.stall, 0);
        tick(1'b1, 1'b1);
        chk("e1_cap", b0.cap, 0);
        edge_after(10);
        chk("e2_cap", b0.cap, 1);
        chk("e2_q0", b0.q[7:0], 10);
        chk("e2_valid", b0.valid, 3'b001);
        chk("e2_gap", b0.gap, 0);
        edge_after(10);
        chk("e3_gap", b0.gap, 0);
        edge_after(10);
        chk("e4_valid", b0.valid, 3'b111);
        chk("e4_q", b0.q, 24'h0a0a0a);
        chk("e4_gap", b0.gap, 0);
        tick(1'b0, 1'b1);
        chk("cap_1cyc", b0.cap, 0);

        // 2: gap detection
        edge_after(9);
        edge_after(10);
        chk("p10_gap", b0.gap, 0);
        edge_after(25);
        chk("p25_cap", b0.cap, 1);
        chk("p25_gap", b0.gap, 1);
        edge_after(20);
        chk("p20_gap", b0.gap, 0);
        chk("p20_q", b0.q, 24'h0a1914);
        do_reset();
        tick(1'b1, 1'b1);
        edge_after(100);
        chk("nov_cap", b0.cap, 1);
        chk("nov_gap", b0.gap, 0);
        chk("nov_valid", b0.valid, 3'b001);

        // 3: stall
        do_reset();
        tick(1'b1, 1'b1);
        edge_after(10);
        repeat (253) tick(1'b0, 1'b1);
        chk("pre_stall", b0.stall, 0);
        tick(1'b0, 1'b1);
        chk("stall", b0.stall, 1);
        chk("stall_valid", b0.valid, 0);
        chk("stall_q0", b0.q[7:0], 10);
        repeat (5) tick(1'b0, 1'b1);
        chk("stall_hold", b0.stall, 1);
        tick(1'b1, 1'b1);
        chk("unstall", b0.stall, 0);
        chk("unstall_cap", b0.cap, 0);
        edge_after(7);
        chk("s7_cap", b0.cap, 1);
        chk("s7_q0", b0.q[7:0], 7);
        chk("s7_valid", b0.valid, 3'b001);
        edge_after(254);
        chk("s254_q0", b0.q[7:0], 254);
        chk("s254_cap", b0.cap, 1);
        chk("s254_gap", b0.gap, 1);
        chk("s254_stall", b0.stall, 0);

        // 4: ena gating
        repeat (4) tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        chk("dis_cap", b0.cap, 0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        repeat (5) tick(1'b0, 1'b1);
        chk("gate_nocap", b0.cap, 0);
        tick(1'b1, 1'b1);
        chk("gate_q0", b0.q[7:0], 10);
        chk("gate_cap", b0.cap, 1);

        // 5: reset mid-period with edge
        repeat (3) tick(1'b0, 1'b1);
        rst = 1'b1;
        tick(1'b1, 1'b1);
        rst = 1'b0;
        chk("mrst_q", b0.q, 0);
        chk("mrst_valid", b0.valid, 0);
        chk("mrst_cap", b0.cap, 0);
        chk("mrst_stall", b0.stall, 0);
        tick(1'b1, 1'b1);
        chk("mrst_ref", b0.cap, 0);
        edge_after(5);
        chk("mrst_q0", b0.q[7:0], 5);
        chk("mrst_v", b0.valid, 3'b001);

        // 6: DEPTH=5, GAP_SHL=2 against model
        m_step(1'b1, 1'b0, 1'b1);
        m_step(1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 40; k++) begin
            int p;
            int n;
            p = $urandom_range(2, 200);
            n = 0;
            while (n < p - 1) begin
                if ($urandom_range(0, 7) == 0) begin
                    m_step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
                end else begin
                    m_step(1'b0, 1'b0, 1'b1);
                    n++;
                end
            end
            m_step(1'b0, 1'b1, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
